// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if: bundle of every signal between the adder arbiter, its
// requesters, the shared adder and the response consumer.
//   req_valid/req_ready/req_a/req_b : per-requester operand channels (packed)
//   add_a/add_b/add_en/add_sum/add_carry : shared adder datapath
//   rsp_valid/rsp_ready/rsp_id/rsp_sum/rsp_carry : tagged response channel
//   op_count : completed-operation counter
// Modports: slave = the arbiter itself, master = the surrounding logic.
interface adder_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*DW-1:0] req_a;
  logic [N_REQ*DW-1:0] req_b;
  logic [DW-1:0]       add_a;
  logic [DW-1:0]       add_b;
  logic                add_en;
  logic [DW-1:0]       add_sum;
  logic                add_carry;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [DW-1:0]       rsp_sum;
  logic                rsp_carry;
  logic [15:0]         op_count;

  modport slave (
    input  req_valid, req_a, req_b, add_sum, add_carry, rsp_ready,
    output req_ready, add_a, add_b, add_en, rsp_valid, rsp_id, rsp_sum,
           rsp_carry, op_count
  );

  modport master (
    output req_valid, req_a, req_b, add_sum, add_carry, rsp_ready,
    input  req_ready, add_a, add_b, add_en, rsp_valid, rsp_id, rsp_sum,
           rsp_carry, op_count
  );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one adder between N_REQ requesters. A round-robin
// pick in IDLE accepts one operand pair, the operands are held on the adder
// for ADD_LAT cycles, then sum/carry are captured and returned on a single
// response channel tagged with the requester id. One operation in flight.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : adder_arbiter_if.slave (request, adder and response channels)
//
// state | meaning
// IDLE  | arbitrate; req_ready to the winner, latch its operands
// WAIT  | operands on the adder, add_en high, count down ADD_LAT cycles
// RESP  | response presented, held until rsp_ready
module adder_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 8,
  parameter int ADD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  adder_arbiter_if.slave   bus
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  last_grant_q;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  gnt_idx;
  logic [ID_W-1:0]  scan_idx;
  logic             gnt_found;
  logic [DW-1:0]    sel_a, sel_b;
  logic [DW-1:0]    op_a_q, op_b_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [DW-1:0]    rsp_sum_q;
  logic             rsp_carry_q;
  logic [15:0]      op_count_q;
  logic [N_REQ-1:0] req_ready_c;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = ID_W'((int'(last_grant_q) + k) % N_REQ);
      if (!gnt_found && bus.req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_a = bus.req_a[i*DW +: DW];
        sel_b = bus.req_b[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // req_ready is gated by rst so a requester never sees an accept that the
  // held-in-reset registers cannot take.
  always_comb begin
    state_d     = state_q;
    req_ready_c = '0;
    case (state_q)
      IDLE: begin
        if (gnt_found && !rst) begin
          req_ready_c[gnt_idx] = 1'b1;
          state_d              = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= ID_W'(N_REQ - 1);
      id_q         <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      cnt_q        <= '0;
      rsp_id_q     <= '0;
      rsp_sum_q    <= '0;
      rsp_carry_q  <= 1'b0;
      op_count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            op_a_q       <= sel_a;
            op_b_q       <= sel_b;
            id_q         <= gnt_idx;
            last_grant_q <= gnt_idx;
            cnt_q        <= CNT_W'(ADD_LAT);
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            rsp_sum_q   <= bus.add_sum;
            rsp_carry_q <= bus.add_carry;
            rsp_id_q    <= id_q;
          end
        end
        RESP: begin
          if (bus.rsp_ready) op_count_q <= op_count_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Operand registers drive the adder directly, so add_a/add_b keep their
  // last values outside WAIT; add_en tells the adder when they matter.
  assign bus.req_ready = req_ready_c;
  assign bus.add_a     = op_a_q;
  assign bus.add_b     = op_b_q;
  assign bus.add_en    = (state_q == WAIT);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: self-checking bench for adder_arbiter. Two instances:
// dut1 with ADD_LAT=1 (combinational adder model) and dut3 with ADD_LAT=3
// (adder model delayed by two register stages, junk when add_en is low).
// Expected responses are pushed when a request is accepted and compared
// against responses collected from the DUT.
module tb_adder_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_arbiter_if #(.N_REQ(4), .DW(8)) bus1 ();
  adder_arbiter_if #(.N_REQ(4), .DW(8)) bus3 ();

  adder_arbiter #(.N_REQ(4), .DW(8), .ADD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  adder_arbiter #(.N_REQ(4), .DW(8), .ADD_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  assign {bus1.add_carry, bus1.add_sum} =
    bus1.add_en ? ({1'b0, bus1.add_a} + {1'b0, bus1.add_b}) : 9'h0AA;

  logic [8:0] st1, st2;
  always @(posedge clk) begin
    st1 <= bus3.add_en ? ({1'b0, bus3.add_a} + {1'b0, bus3.add_b}) : 9'h155;
    st2 <= st1;
  end
  assign {bus3.add_carry, bus3.add_sum} = st2;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] sum;
    logic       carry;
  } res_t;

  int   n_cmp = 0;
  int   n_fail = 0;
  logic [7:0] pa [4][8];
  logic [7:0] pb [4][8];
  int   n_ops [4];
  int   idx_op [4];
  res_t exp_q [$];
  res_t got_q [$];
  int   grant_log [$];
  int   n_push, n_got;
  int   cyc = 0;
  int   grant_cyc, rsp_cyc, ready_cycles;
  logic prev_rsp = 1'b0;

  function automatic bit all_issued();
    for (int i = 0; i < 4; i++) if (idx_op[i] < n_ops[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < 4; i++) begin
      if (idx_op[i] < n_ops[i]) begin
        bus1.req_valid[i]     = 1'b1;
        bus1.req_a[i*8 +: 8]  = pa[i][idx_op[i]];
        bus1.req_b[i*8 +: 8]  = pb[i][idx_op[i]];
      end else begin
        bus1.req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic clear_ops();
    for (int i = 0; i < 4; i++) begin
      n_ops[i]  = 0;
      idx_op[i] = 0;
    end
    drive_reqs();
  endtask

  task automatic reset_sb();
    exp_q.delete();
    got_q.delete();
    grant_log.delete();
    n_push = 0;
    n_got  = 0;
  endtask

  // One cycle: sample at negedge, then update drivers just after posedge.
  task automatic step();
    int g;
    logic [8:0] s;
    @(negedge clk);
    cyc++;
    g = -1;
    if (bus1.req_ready != 4'b0) ready_cycles++;
    for (int i = 0; i < 4; i++) if (bus1.req_ready[i] && bus1.req_valid[i]) g = i;
    if (g >= 0) begin
      s = {1'b0, pa[g][idx_op[g]]} + {1'b0, pb[g][idx_op[g]]};
      exp_q.push_back('{id: 2'(g), sum: s[7:0], carry: s[8]});
      grant_log.push_back(g);
      grant_cyc = cyc;
      n_push++;
    end
    if (bus1.rsp_valid && !prev_rsp) rsp_cyc = cyc;
    prev_rsp = bus1.rsp_valid;
    if (bus1.rsp_valid && bus1.rsp_ready) begin
      got_q.push_back('{id: bus1.rsp_id, sum: bus1.rsp_sum, carry: bus1.rsp_carry});
      n_got++;
    end
    @(posedge clk);
    #1;
    if (g >= 0) idx_op[g]++;
    drive_reqs();
  endtask

  task automatic run(input int max_cyc, output bit done);
    int c = 0;
    while (!(all_issued() && n_got == n_push) && c < max_cyc) begin
      step();
      c++;
    end
    done = all_issued() && (n_got == n_push);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_ops();
    bus1.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    reset_sb();
    prev_rsp = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    n_cmp++; if (bus1.req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", bus1.req_ready); end
    n_cmp++; if ({bus1.add_a, bus1.add_b} !== 16'h0) begin n_fail++; $display("FAIL reset_add_ab: got %h want 0000", {bus1.add_a, bus1.add_b}); end
    n_cmp++; if (bus1.add_en !== 1'b0) begin n_fail++; $display("FAIL reset_add_en: got %b want 0", bus1.add_en); end
    n_cmp++; if (bus1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus1.rsp_valid); end
    n_cmp++; if ({bus1.rsp_id, bus1.rsp_sum, bus1.rsp_carry} !== 11'h0) begin n_fail++; $display("FAIL reset_rsp_fields: got %h want 0", {bus1.rsp_id, bus1.rsp_sum, bus1.rsp_carry}); end
    n_cmp++; if (bus1.op_count !== 16'h0) begin n_fail++; $display("FAIL reset_op_count: got %h want 0000", bus1.op_count); end
    n_cmp++; if ({bus3.rsp_valid, bus3.add_en, bus3.op_count} !== 18'h0) begin n_fail++; $display("FAIL reset_dut3: got %h want 0", {bus3.rsp_valid, bus3.add_en, bus3.op_count}); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit done;
    res_t e, g;
    clear_ops();
    reset_sb();
    bus1.rsp_ready = 1'b1;
    ready_cycles = 0;
    n_ops[2] = 1; pa[2][0] = 8'h12; pb[2][0] = 8'h34;
    drive_reqs();
    run(20, done);
    n_cmp++; if (!done) begin n_fail++; $display("FAIL single_timeout: got done=0 want 1"); end
    n_cmp++; if (grant_log.size() != 1 || grant_log[0] != 2) begin n_fail++; $display("FAIL single_grant: got %0d grants want one grant to 2", grant_log.size()); end
    n_cmp++; if (ready_cycles != 1) begin n_fail++; $display("FAIL single_ready_cycles: got %0d want 1", ready_cycles); end
    n_cmp++; if (rsp_cyc - grant_cyc != 2) begin n_fail++; $display("FAIL single_latency: got %0d want 2", rsp_cyc - grant_cyc); end
    if (got_q.size() > 0) begin
      n_cmp++; if (got_q[0] !== res_t'({2'd2, 8'h46, 1'b0})) begin n_fail++; $display("FAIL single_rsp_const: got %h want %h", got_q[0], res_t'({2'd2, 8'h46, 1'b0})); end
    end
    while (exp_q.size() > 0 || got_q.size() > 0) begin
      n_cmp++;
      if (exp_q.size() == 0 || got_q.size() == 0) begin n_fail++; $display("FAIL single_count: got %0d rsp want %0d", got_q.size(), exp_q.size()); break; end
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin n_fail++; $display("FAIL single_sb: got %h want %h", g, e); end
    end
    n_cmp++; if (bus1.op_count !== 16'd1) begin n_fail++; $display("FAIL single_op_count: got %0d want 1", bus1.op_count); end
  endtask

  task automatic test_carry();
    bit done;
    res_t e, g;
    clear_ops();
    reset_sb();
    n_ops[1] = 2;
    pa[1][0] = 8'hFF; pb[1][0] = 8'h01;
    pa[1][1] = 8'h80; pb[1][1] = 8'h80;
    drive_reqs();
    run(30, done);
    n_cmp++; if (!done) begin n_fail++; $display("FAIL carry_timeout: got done=0 want 1"); end
    for (int k = 0; k < 2; k++) begin
      if (got_q.size() > k) begin
        n_cmp++; if (got_q[k] !== res_t'({2'd1, 8'h00, 1'b1})) begin n_fail++; $display("FAIL carry_rsp%0d: got %h want %h", k, got_q[k], res_t'({2'd1, 8'h00, 1'b1})); end
      end
    end
    while (exp_q.size() > 0 || got_q.size() > 0) begin
      n_cmp++;
      if (exp_q.size() == 0 || got_q.size() == 0) begin n_fail++; $display("FAIL carry_count: got %0d rsp want %0d", got_q.size(), exp_q.size()); break; end
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin n_fail++; $display("FAIL carry_sb: got %h want %h", g, e); end
    end
    n_cmp++; if (bus1.op_count !== 16'd3) begin n_fail++; $display("FAIL carry_op_count: got %0d want 3", bus1.op_count); end
  endtask

  task automatic test_fairness();
    bit done;
    res_t e, g;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      n_ops[i] = 8;
      for (int k = 0; k < 8; k++) begin
        pa[i][k] = 8'($urandom);
        pb[i][k] = 8'($urandom);
      end
    end
    drive_reqs();
    run(400, done);
    n_cmp++; if (!done) begin n_fail++; $display("FAIL rr_timeout: got done=0 want 1"); end
    n_cmp++; if (grant_log.size() != 32) begin n_fail++; $display("FAIL rr_grants: got %0d want 32", grant_log.size()); end
    for (int k = 0; k < grant_log.size(); k++) begin
      n_cmp++;
      if (grant_log[k] != k % 4) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, grant_log[k], k % 4); end
    end
    while (exp_q.size() > 0 || got_q.size() > 0) begin
      n_cmp++;
      if (exp_q.size() == 0 || got_q.size() == 0) begin n_fail++; $display("FAIL rr_count: got %0d rsp want %0d", got_q.size(), exp_q.size()); break; end
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin n_fail++; $display("FAIL rr_sb: got %h want %h", g, e); end
    end
    n_cmp++; if (bus1.op_count !== 16'd32) begin n_fail++; $display("FAIL rr_op_count: got %0d want 32", bus1.op_count); end
  endtask

  task automatic test_backpressure();
    bit done;
    int c;
    res_t e, g;
    do_reset();
    bus1.rsp_ready = 1'b0;
    n_ops[3] = 1; pa[3][0] = 8'h5A; pb[3][0] = 8'hC3;
    drive_reqs();
    c = 0;
    while (!prev_rsp && c < 10) begin step(); c++; end
    n_cmp++; if (!prev_rsp) begin n_fail++; $display("FAIL bp_rsp_timeout: got rsp_valid=0 want 1"); end
    n_ops[0] = 1; pa[0][0] = 8'h01; pb[0][0] = 8'h02;
    drive_reqs();
    ready_cycles = 0;
    for (int h = 0; h < 5; h++) begin
      step();
      n_cmp++; if (bus1.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", h, bus1.rsp_valid); end
      n_cmp++; if ({bus1.rsp_id, bus1.rsp_sum, bus1.rsp_carry} !== {2'd3, 8'h1D, 1'b1}) begin n_fail++; $display("FAIL bp_fields[%0d]: got %h want %h", h, {bus1.rsp_id, bus1.rsp_sum, bus1.rsp_carry}, {2'd3, 8'h1D, 1'b1}); end
      n_cmp++; if (bus1.op_count !== 16'd0) begin n_fail++; $display("FAIL bp_op_count[%0d]: got %0d want 0", h, bus1.op_count); end
    end
    n_cmp++; if (ready_cycles != 0) begin n_fail++; $display("FAIL bp_req_ready: got %0d ready cycles want 0", ready_cycles); end
    bus1.rsp_ready = 1'b1;
    run(20, done);
    n_cmp++; if (!done) begin n_fail++; $display("FAIL bp_timeout: got done=0 want 1"); end
    while (exp_q.size() > 0 || got_q.size() > 0) begin
      n_cmp++;
      if (exp_q.size() == 0 || got_q.size() == 0) begin n_fail++; $display("FAIL bp_count: got %0d rsp want %0d", got_q.size(), exp_q.size()); break; end
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin n_fail++; $display("FAIL bp_sb: got %h want %h", g, e); end
    end
    n_cmp++; if (bus1.op_count !== 16'd2) begin n_fail++; $display("FAIL bp_op_count_end: got %0d want 2", bus1.op_count); end
  endtask

  task automatic test_latency();
    int t_g, t_r, en_cnt;
    logic [8:0] s;
    res_t exp3_q [$];
    res_t e, g;
    t_g = -1; t_r = -1; en_cnt = 0;
    bus3.rsp_ready = 1'b1;
    bus3.req_a = '0; bus3.req_b = '0;
    bus3.req_a[15:8] = 8'h7F;
    bus3.req_b[15:8] = 8'h90;
    bus3.req_valid = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus3.req_ready != 4'b0 && t_g < 0) begin
        t_g = c;
        n_cmp++; if (bus3.req_ready !== 4'b0010) begin n_fail++; $display("FAIL lat_grant: got %b want 0010", bus3.req_ready); end
        s = {1'b0, 8'h7F} + {1'b0, 8'h90};
        exp3_q.push_back('{id: 2'd1, sum: s[7:0], carry: s[8]});
      end
      if (bus3.add_en) begin
        en_cnt++;
        n_cmp++; if ({bus3.add_a, bus3.add_b} !== 16'h7F90) begin n_fail++; $display("FAIL lat_operands: got %h want 7f90", {bus3.add_a, bus3.add_b}); end
      end
      if (bus3.rsp_valid && t_r < 0) begin
        t_r = c;
        g = '{id: bus3.rsp_id, sum: bus3.rsp_sum, carry: bus3.rsp_carry};
        n_cmp++;
        if (exp3_q.size() == 0) begin n_fail++; $display("FAIL lat_sb: got %h want none", g); end
        else begin
          e = exp3_q.pop_front();
          if (g !== e) begin n_fail++; $display("FAIL lat_sb: got %h want %h", g, e); end
        end
      end
      @(posedge clk);
      #1;
      if (t_g >= 0) bus3.req_valid = 4'b0;
      if (t_r >= 0) break;
    end
    n_cmp++; if (t_g < 0 || t_r < 0) begin n_fail++; $display("FAIL lat_timeout: got grant=%0d rsp=%0d want both seen", t_g, t_r); end
    n_cmp++; if (en_cnt != 3) begin n_fail++; $display("FAIL lat_add_en_cycles: got %0d want 3", en_cnt); end
    n_cmp++; if (t_r - t_g != 4) begin n_fail++; $display("FAIL lat_latency: got %0d want 4", t_r - t_g); end
    n_cmp++; if (bus3.op_count !== 16'd1) begin n_fail++; $display("FAIL lat_op_count: got %0d want 1", bus3.op_count); end
  endtask

  task automatic test_reset_mid();
    bit done, found;
    res_t e, g;
    clear_ops();
    reset_sb();
    bus1.rsp_ready = 1'b1;
    n_ops[2] = 1; pa[2][0] = 8'hAB; pb[2][0] = 8'hCD;
    drive_reqs();
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus1.add_en === 1'b1) begin found = 1'b1; break; end
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL mid_wait_timeout: got add_en=0 want 1"); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({bus1.add_en, bus1.rsp_valid, bus1.req_ready} !== 6'b0) begin n_fail++; $display("FAIL mid_ctrl: got %b want 000000", {bus1.add_en, bus1.rsp_valid, bus1.req_ready}); end
    n_cmp++; if ({bus1.add_a, bus1.add_b, bus1.op_count} !== 32'h0) begin n_fail++; $display("FAIL mid_data: got %h want 0", {bus1.add_a, bus1.add_b, bus1.op_count}); end
    clear_ops();
    n_ops[0] = 1; pa[0][0] = 8'h11; pb[0][0] = 8'h22;
    n_ops[1] = 1; pa[1][0] = 8'h33; pb[1][0] = 8'h44;
    drive_reqs();
    @(posedge clk);
    #1;
    n_cmp++; if ({bus1.rsp_valid, bus1.req_ready} !== 5'b0) begin n_fail++; $display("FAIL mid_in_reset: got %b want 00000", {bus1.rsp_valid, bus1.req_ready}); end
    rst = 1'b0;
    reset_sb();
    prev_rsp = 1'b0;
    run(30, done);
    n_cmp++; if (!done) begin n_fail++; $display("FAIL mid_timeout: got done=0 want 1"); end
    n_cmp++; if (grant_log.size() < 1 || grant_log[0] != 0) begin n_fail++; $display("FAIL mid_first_grant: got %0d want 0", grant_log.size() > 0 ? grant_log[0] : -1); end
    while (exp_q.size() > 0 || got_q.size() > 0) begin
      n_cmp++;
      if (exp_q.size() == 0 || got_q.size() == 0) begin n_fail++; $display("FAIL mid_count: got %0d rsp want %0d", got_q.size(), exp_q.size()); break; end
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin n_fail++; $display("FAIL mid_sb: got %h want %h", g, e); end
    end
    n_cmp++; if (bus1.op_count !== 16'd2) begin n_fail++; $display("FAIL mid_op_count: got %0d want 2", bus1.op_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus1.req_valid = '0; bus1.req_a = '0; bus1.req_b = '0; bus1.rsp_ready = 1'b0;
    bus3.req_valid = '0; bus3.req_a = '0; bus3.req_b = '0; bus3.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_ops[i] = 0;
      idx_op[i] = 0;
    end
    reset_sb();
    test_reset();
    test_single();
    test_carry();
    test_fairness();
    test_backpressure();
    test_latency();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
